control_sequencer: RTL

Microcoded control sequencer for the 4-bit-address teaching computer. Steps a fixed five-cycle fetch/execute ring, decodes the instruction register's opcode nibble, and drives the level control strobes of the program counter, MAR, RAM, IR, A/B registers, ALU and output register. It is the only block that enables, loads, or reads out the program counter.

---
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Five-step fetch/execute control sequencer for the 4-bit-address teaching computer.
// Optional macro SEQ_JUMP_EN enables decode of JMP (0x6) and JZ (0x7).
module control_sequencer #(
   parameter int OPW = 4
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic           hold,
   input  logic [OPW-1:0] ir_op,
   input  logic           zero_flag,
   output logic           pc_en,
   output logic           pc_oe,
   output logic           pc_we,
   output logic           mar_we,
   output logic           ram_oe,
   output logic           ram_we,
   output logic           ir_we,
   output logic           ir_oe,
   output logic           a_we,
   output logic           a_oe,
   output logic           b_we,
   output logic           alu_oe,
   output logic           alu_sub,
   output logic           flags_we,
   output logic           out_we,
   output logic [2:0]     tstate,
   output logic           halted
);

   // state   | meaning
   // ST_F0   | fetch: PC onto bus, load MAR
   // ST_F1   | fetch: RAM into IR, increment PC
   // ST_E0   | execute step 0 (operand/address, jumps, HLT decision)
   // ST_E1   | execute step 1 (memory access)
   // ST_E2   | execute step 2 (ALU write-back)
   // ST_HALT | stopped until RESET
   typedef enum logic [2:0] {
      ST_F0   = 3'd0,
      ST_F1   = 3'd1,
      ST_E0   = 3'd2,
      ST_E1   = 3'd3,
      ST_E2   = 3'd4,
      ST_HALT = 3'd7
   } state_t;

   localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
`ifdef SEQ_JUMP_EN
   localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h7);
`endif
   localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
   localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

   state_t state, state_nxt;
   logic   strobe_en;

`ifndef SEQ_JUMP_EN
   logic unused_zero_flag;
   assign unused_zero_flag = zero_flag;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_F0;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!hold) begin
         case (state)
            ST_F0:   state_nxt = ST_F1;
            ST_F1:   state_nxt = ST_E0;
            ST_E0:   state_nxt = (ir_op == OP_HLT) ? ST_HALT : ST_E1;
            ST_E1:   state_nxt = ST_E2;
            ST_E2:   state_nxt = ST_F0;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_F0;
         endcase
      end
      // HALT is absorbing regardless of hold
      if (state == ST_HALT) state_nxt = ST_HALT;
   end

   assign strobe_en = !RESET && !hold && (state != ST_HALT);
   assign tstate    = state;
   assign halted    = (state == ST_HALT);

   always_comb begin
      pc_en    = 1'b0;
      pc_oe    = 1'b0;
      pc_we    = 1'b0;
      mar_we   = 1'b0;
      ram_oe   = 1'b0;
      ram_we   = 1'b0;
      ir_we    = 1'b0;
      ir_oe    = 1'b0;
      a_we     = 1'b0;
      a_oe     = 1'b0;
      b_we     = 1'b0;
      alu_oe   = 1'b0;
      alu_sub  = 1'b0;
      flags_we = 1'b0;
      out_we   = 1'b0;
      if (strobe_en) begin
         case (state)
            ST_F0: begin
               pc_oe  = 1'b1;
               mar_we = 1'b1;
            end
            ST_F1: begin
               ram_oe = 1'b1;
               ir_we  = 1'b1;
               pc_en  = 1'b1;
            end
            ST_E0: begin
               case (ir_op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_oe  = 1'b1;
                     mar_we = 1'b1;
                  end
                  OP_LDI: begin
                     ir_oe = 1'b1;
                     a_we  = 1'b1;
                  end
`ifdef SEQ_JUMP_EN
                  OP_JMP: begin
                     ir_oe = 1'b1;
                     pc_we = 1'b1;
                  end
                  OP_JZ: begin
                     ir_oe = zero_flag;
                     pc_we = zero_flag;
                  end
`endif
                  OP_OUT: begin
                     a_oe   = 1'b1;
                     out_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_E1: begin
               case (ir_op)
                  OP_LDA: begin
                     ram_oe = 1'b1;
                     a_we   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_oe = 1'b1;
                     b_we   = 1'b1;
                  end
                  OP_STA: begin
                     a_oe   = 1'b1;
                     ram_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_E2: begin
               if (ir_op == OP_ADD || ir_op == OP_SUB) begin
                  alu_oe   = 1'b1;
                  a_we     = 1'b1;
                  flags_we = 1'b1;
                  alu_sub  = (ir_op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
